ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Arbitrates a single 64K SRAM between the flash image loader, the 6502 CPU
//   and a diagnostics port.  After reset the flash loader owns the RAM until
//   read_complete; the CPU then owns it.  A diagnostics halt request pulls rdy
//   low, waits for the CPU to finish any pending writes (two consecutive read
//   cycles observed on phi2), then hands the RAM to single diagnostics accesses.
//
// Ports
//   clk, reset            system clock, synchronous active-low reset
//   read_complete         flash image load finished
//   owner[1:0]            00 flash, 01 CPU, 10 diagnostics
//   phi2, rwbar           CPU clock (asynchronous to clk) and read/write
//   cpu_cs/we/address     CPU RAM access, wdatain = CPU write data
//   halted                CPU held (rdy = !halted externally)
//   flash_cs/we/address/datain   loader RAM access
//   halt_req              level request to halt the CPU
//   diag_req/we/address/datain   single access, req held until diag_ack
//   diag_ack              one-cycle pulse marking access complete
//   ram_cs/we/address/datain     to sram64k
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_complete,
  output logic [1:0]  owner,
  input  logic        phi2,
  input  logic        rwbar,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  wdatain,
  output logic        halted,
  input  logic        flash_cs,
  input  logic        flash_we,
  input  logic [15:0] flash_address,
  input  logic [7:0]  flash_datain,
  input  logic        halt_req,
  input  logic        diag_req,
  input  logic        diag_we,
  input  logic [15:0] diag_address,
  input  logic [7:0]  diag_datain,
  output logic        diag_ack,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_datain
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_HALT_WAIT,
    S_HALTED,
    S_DIAG_ACCESS
  } state_e;

  state_e      state_q, state_d;

  logic        phi2_s1_q, phi2_s2_q, phi2_prev_q;
  logic        rw_s1_q, rw_s2_q, rw_prev_q;
  logic [1:0]  rd_cnt_q, rd_cnt_d;
  logic        diag_phase_q, diag_phase_d;
  logic        diag_block_q, diag_block_d;
  logic        diag_we_q;
  logic [15:0] diag_addr_q;
  logic [7:0]  diag_data_q;
  logic        latch_en;
  logic        phi2_fall;
  logic        diag_go;

  // Falling edge seen two flops deep; it acts on the third clk edge after the pin fell.
  assign phi2_fall = phi2_prev_q & ~phi2_s2_q;

  // rwbar runs through an identical pipeline so rw_prev_q is the value sampled
  // alongside the last phi2-high sample, i.e. the direction of the cycle that just ended.

  // A request still high after its ack is stale until the requester drops it.
  assign diag_go = diag_req & ~diag_block_q;
  assign diag_block_d = diag_req & (diag_block_q | diag_ack);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      phi2_s1_q    <= 1'b0;
      phi2_s2_q    <= 1'b0;
      phi2_prev_q  <= 1'b0;
      rw_s1_q      <= 1'b0;
      rw_s2_q      <= 1'b0;
      rw_prev_q    <= 1'b0;
      rd_cnt_q     <= '0;
      diag_phase_q <= 1'b0;
      diag_block_q <= 1'b0;
      diag_we_q    <= 1'b0;
      diag_addr_q  <= '0;
      diag_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      phi2_s1_q    <= phi2;
      phi2_s2_q    <= phi2_s1_q;
      phi2_prev_q  <= phi2_s2_q;
      rw_s1_q      <= rwbar;
      rw_s2_q      <= rw_s1_q;
      rw_prev_q    <= rw_s2_q;
      rd_cnt_q     <= rd_cnt_d;
      diag_phase_q <= diag_phase_d;
      diag_block_q <= diag_block_d;
      if (latch_en) begin
        diag_we_q   <= diag_we;
        diag_addr_q <= diag_address;
        diag_data_q <= diag_datain;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = '0;
    diag_phase_d = 1'b0;
    latch_en     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (read_complete) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_req) state_d = S_HALT_WAIT;
      end
      S_HALT_WAIT: begin
        if (!halt_req) begin
          state_d = S_RUN;
        end else begin
          rd_cnt_d = rd_cnt_q;
          if (phi2_fall) rd_cnt_d = rw_prev_q ? rd_cnt_q + 2'd1 : 2'd0;
          // Two consecutive reads mean the CPU has no write left in flight.
          if (rd_cnt_d == 2'd2) state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (diag_go) begin
          latch_en = 1'b1;
          state_d  = S_DIAG_ACCESS;
        end else if (!halt_req) begin
          state_d = S_RUN;
        end
      end
      S_DIAG_ACCESS: begin
        diag_phase_d = ~diag_phase_q;
        if (diag_phase_q) state_d = S_HALTED;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    owner       = 2'b00;
    halted      = 1'b0;
    diag_ack    = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_address = diag_addr_q;
    ram_datain  = diag_data_q;
    case (state_q)
      S_LOAD: begin
        ram_cs      = flash_cs;
        ram_we      = flash_we;
        ram_address = flash_address;
        ram_datain  = flash_datain;
      end
      S_RUN, S_HALT_WAIT: begin
        owner       = 2'b01;
        halted      = (state_q == S_HALT_WAIT);
        ram_cs      = cpu_cs;
        ram_we      = cpu_we;
        ram_address = cpu_address;
        ram_datain  = wdatain;
      end
      S_HALTED: begin
        owner  = 2'b10;
        halted = 1'b1;
      end
      S_DIAG_ACCESS: begin
        owner    = 2'b10;
        halted   = 1'b1;
        ram_cs   = 1'b1;
        ram_we   = diag_we_q;
        diag_ack = diag_phase_q & reset;
      end
      default: begin
        owner = 2'b00;
      end
    endcase
    // Reset low keeps the RAM quiet even though LOAD mirrors the loader.
    if (!reset) begin
      ram_cs = 1'b0;
      ram_we = 1'b0;
    end
  end

endmodule
